mux_21: RTL and testbench



---
 rtl/mux_21_pkg.sv | 13 +
 rtl/mux_21.sv | 42 ++++
 tb/tb_mux_21.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mux_21_pkg.sv
// Shared datapath widths and select encoding for the memory-control stage.
// Instantiators pass DATA_W or ADDR_W as the selector's WIDTH.
package mux_21_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_21.sv
// Parameterised 2:1 data selector (writeback source / memory address source).
// Combinational by default; REGISTERED=1 adds one output flop with async reset.
module mux_21
  import mux_21_pkg::*;
#(
  parameter int               WIDTH       = DATA_W,
  parameter bit               REGISTERED  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] sel_data;

  // Bit-for-bit selection; an X/Z select is allowed to propagate X.
  assign sel_data = (sel == 1'(SEL_B)) ? in_b : in_a;

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= RESET_VALUE;
        else     out_q <= sel_data;
      end

      assign out = out_q;
    end else begin : g_comb
      // clk and rst have no role in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign out = sel_data;
    end
  endgenerate

endmodule

// File: tb/tb_mux_21.sv
// Directed bench for mux_21: combinational 32/16-bit builds, positional hookups
// and the registered build with asynchronous reset, checked via a scoreboard.
module tb_mux_21;
  import mux_21_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // combinational 32-bit
  logic              c_sel;
  logic [DATA_W-1:0] c_a, c_b, c_out, p_out32;
  // combinational 16-bit
  logic              a_sel;
  logic [ADDR_W-1:0] a_a, a_b, a_out, p_out16;
  // registered 32-bit
  logic              r_sel;
  logic [DATA_W-1:0] r_a, r_b, r_out;

  mux_21 #(.WIDTH(DATA_W), .REGISTERED(1'b0)) u_comb32 (
    .sel(c_sel), .in_a(c_a), .in_b(c_b), .out(c_out), .clk(clk), .rst(rst));

  mux_21 #(.WIDTH(ADDR_W), .REGISTERED(1'b0)) u_comb16 (
    .sel(a_sel), .in_a(a_a), .in_b(a_b), .out(a_out), .clk(clk), .rst(rst));

  mux_21 #(.WIDTH(DATA_W), .REGISTERED(1'b1), .RESET_VALUE(32'h0)) u_reg32 (
    .sel(r_sel), .in_a(r_a), .in_b(r_b), .out(r_out), .clk(clk), .rst(rst));

  // Positional hookups in the legacy order sel, A, B, out, then clk, rst.
  mux_21 #(DATA_W) u_pos32 (c_sel, c_a, c_b, p_out32, clk, rst);
  mux_21 #(ADDR_W) u_pos16 (a_sel, a_a, a_b, p_out16, clk, rst);

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed %h, scoreboard had no expected value", tag, observed);
      return;
    end
    expected = exp_q.pop_front();
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // driver tasks: each pushes the reference result(s) for what it drives
  task automatic drive_comb32(input logic s, input logic [31:0] a, input logic [31:0] b);
    c_sel = s; c_a = a; c_b = b;
    exp_q.push_back(s ? b : a);
    exp_q.push_back(s ? b : a);
  endtask

  task automatic drive_comb16(input logic s, input logic [15:0] a, input logic [15:0] b);
    a_sel = s; a_a = a; a_b = b;
    exp_q.push_back({16'h0, (s ? b : a)});
    exp_q.push_back({16'h0, (s ? b : a)});
  endtask

  task automatic drive_reg(input logic s, input logic [31:0] a, input logic [31:0] b);
    r_sel = s; r_a = a; r_b = b;
  endtask

  task automatic check_comb32(input string tag);
    #1;
    check(tag, c_out);
    check({tag, "_pos"}, p_out32);
  endtask

  task automatic check_comb16(input string tag);
    #1;
    check(tag, {16'h0, a_out});
    check({tag, "_pos"}, {16'h0, p_out16});
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    logic        rs;
    c_sel = 0; c_a = '0; c_b = '0;
    a_sel = 0; a_a = '0; a_b = '0;
    drive_reg(1'b0, 32'h0, 32'h0);

    // combinational 32-bit, select toggles without a clock edge
    drive_comb32(1'b0, 32'h0000_00AA, 32'hDEAD_BEEF); check_comb32("c32_sel0");
    drive_comb32(1'b1, 32'h0000_00AA, 32'hDEAD_BEEF); check_comb32("c32_sel1");

    // 16-bit address path 0 -> 1 -> 0
    drive_comb16(1'b0, 16'h1234, 16'h00FF); check_comb16("c16_sel0");
    drive_comb16(1'b1, 16'h1234, 16'h00FF); check_comb16("c16_sel1");
    drive_comb16(1'b0, 16'h1234, 16'h00FF); check_comb16("c16_sel0b");
    drive_comb16(1'b1, 16'hFFFF, 16'h8001); check_comb16("c16_edges");

    // tracking: only the selected input matters
    drive_comb32(1'b1, 32'h1357_9BDF, 32'h0); check_comb32("track_b_zero");
    drive_comb32(1'b1, 32'h2468_ACE0, 32'hFFFF_FFFF); check_comb32("track_b_ones");
    for (int i = 0; i < 4; i++) begin
      drive_comb32(1'b1, $urandom, $urandom); check_comb32("track_b_rand");
    end
    drive_comb32(1'b0, 32'h0, 32'hCAFE_F00D); check_comb32("track_a_zero");
    drive_comb32(1'b0, 32'hFFFF_FFFF, 32'h1111_2222); check_comb32("track_a_ones");
    for (int i = 0; i < 4; i++) begin
      drive_comb32(1'b0, $urandom, $urandom); check_comb32("track_a_rand");
      drive_comb16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      check_comb16("c16_rand");
    end

    // registered: async reset takes effect between edges
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(32'h0); #1 check("reg_rst_async", r_out);
    drive_comb32(1'b1, 32'h1, 32'h7777_0000); check_comb32("c32_ignores_rst");

    // release, then exactly one cycle of latency
    @(negedge clk);
    rst = 1'b0;
    drive_reg(1'b1, 32'h0, 32'h5A5A_5A5A);
    exp_q.push_back(32'h0); #1 check("reg_before_edge", r_out);
    @(posedge clk);
    exp_q.push_back(32'h5A5A_5A5A); #1 check("reg_first_capture", r_out);

    held = 32'h5A5A_5A5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rs = 1'($urandom_range(0, 1)); ra = $urandom; rb = $urandom;
      drive_reg(rs, ra, rb);
      exp_q.push_back(held); #1 check("reg_hold", r_out);
      @(posedge clk);
      held = rs ? rb : ra;
      exp_q.push_back(held); #1 check("reg_latency", r_out);
    end

    // reset mid-operation discards data and holds across edges
    @(negedge clk);
    drive_reg(1'b1, 32'h0, 32'h5A5A_5A5A);
    @(posedge clk);
    exp_q.push_back(32'h5A5A_5A5A); #1 check("reg_preload", r_out);
    #2 rst = 1'b1;
    exp_q.push_back(32'h0); #1 check("reg_rst_mid", r_out);
    for (int i = 0; i < 2; i++) begin
      drive_reg(1'b0, $urandom, $urandom);
      @(posedge clk);
      exp_q.push_back(32'h0); #1 check("reg_rst_held", r_out);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_reg(1'b0, 32'h0BAD_CAFE, 32'h5A5A_5A5A);
    exp_q.push_back(32'h0); #1 check("reg_no_recovery", r_out);
    @(posedge clk);
    exp_q.push_back(32'h0BAD_CAFE); #1 check("reg_after_release", r_out);

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
